// File: rtl/outport_arbiter.sv
// outport_arbiter: round-robin sharing of the 8-bit output port register among N_REQ requesters,
// with a 4-phase ready/ack device handshake. Optional handshake abort: define OUTPORT_TIMEOUT_EN.
module outport_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   load,
    output logic                   port_ready,
    input  logic                   ext_ack,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [1:0]             o_dbg_state
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HS   = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_winner;
    logic [WIDTH-1:0] r_bus;
    logic             r_load;
    logic             r_ready;
    logic [N_REQ-1:0] r_done;
    logic             r_busy;

    logic             w_grant_valid;
    logic [IW-1:0]    w_grant;
    logic [WIDTH-1:0] w_grant_data;
    logic [IW-1:0]    w_next_ptr;
    logic             w_timeout;
    int               w_idx;

    // First requester at or after r_rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (!w_grant_valid && req[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = w_idx[IW-1:0];
            end
        end
    end

    assign w_grant_data = data_in[int'(w_grant)*WIDTH +: WIDTH];
    assign w_next_ptr   = (r_winner == IW'(N_REQ-1)) ? '0 : r_winner + 1'b1;

`ifdef OUTPORT_TIMEOUT_EN
    localparam int CW = ($clog2(ACK_TIMEOUT+1) > 8) ? $clog2(ACK_TIMEOUT+1) : 8;
    logic [CW-1:0] r_cnt;
    logic          r_tmo;

    assign w_timeout = (r_state == S_HS) && !ext_ack && (r_cnt == CW'(ACK_TIMEOUT-1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= w_timeout;
            if (r_state == S_LOAD)
                r_cnt <= '0;
            else if (r_state == S_HS && !ext_ack && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
        end
    end
    assign timeout_err = r_tmo;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^ACK_TIMEOUT;
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Device handshake: port_ready rises the cycle after the load strobe and holds until
    // ext_ack is sampled high; the next grant waits until ext_ack has dropped again.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_bus    <= '0;
            r_load   <= 1'b0;
            r_ready  <= 1'b0;
            r_done   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_state  <= S_LOAD;
                        r_bus    <= w_grant_data;
                        r_winner <= w_grant;
                        r_load   <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_HS;
                    r_ready <= 1'b1;
                end
                S_HS: begin
                    if (ext_ack) begin
                        r_state          <= S_REL;
                        r_ready          <= 1'b0;
                        r_done[r_winner] <= 1'b1;
                        r_rr_ptr         <= w_next_ptr;
                    end else if (w_timeout) begin
                        r_state          <= S_IDLE;
                        r_ready          <= 1'b0;
                        r_done[r_winner] <= 1'b1;
                        r_rr_ptr         <= w_next_ptr;
                        r_busy           <= 1'b0;
                    end
                end
                S_REL: begin
                    if (!ext_ack) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_out     = r_bus;
    assign load        = r_load;
    assign port_ready  = r_ready;
    assign done        = r_done;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_outport_arbiter.sv
// tb_outport_arbiter: scoreboard bench for outport_arbiter; loads and done pulses are matched
// against expected {done, data} entries queued when each request is driven.
module tb_outport_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int EW = N + W;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [W-1:0]   bus_out;
    logic           load;
    logic           port_ready;
    logic           ext_ack;
    logic [N-1:0]   done;
    logic           busy;
    logic           timeout_err;
    logic [1:0]     o_dbg_state;

    logic man_ack  = 1'b0;
    logic auto_ack = 1'b0;
    assign ext_ack = auto_ack ? port_ready : man_ack;

    logic [EW-1:0] exp_q[$];
    logic [N-1:0]  exp_done_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic prev_load = 1'b0;

    outport_arbiter #(.N_REQ(N), .WIDTH(W), .ACK_TIMEOUT(10)) dut (
        .clk(clk), .clr(clr), .req(req), .data_in(data_in), .bus_out(bus_out),
        .load(load), .port_ready(port_ready), .ext_ack(ext_ack), .done(done),
        .busy(busy), .timeout_err(timeout_err), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        data_in[i*W +: W] = v;
    endtask

    task automatic push_exp(input logic [N-1:0] d, input logic [W-1:0] v);
        exp_q.push_back({d, v});
    endtask

    task automatic wait_for(input string tag, input int sel, input int max_cyc);
        bit seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            case (sel)
                0:       seen = load;
                1:       seen = port_ready;
                2:       seen = |done;
                default: seen = timeout_err;
            endcase
        end
        if (!seen) check_val({tag, "_wait"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    // Scoreboard: every load must match the oldest queued entry, every done its winner.
    always @(negedge clk) begin
        if (!clr) begin
            if (load) begin
                check_val("load_one_cycle", 32'(prev_load), 32'd0);
                if (exp_q.size() == 0) begin
                    check_val("load_unexpected", 32'(bus_out), 32'hFFFF);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check_val("bus_out_at_load", 32'(bus_out), 32'(e[W-1:0]));
                    exp_done_q.push_back(e[EW-1:W]);
                end
            end
            if (done != '0) begin
                if (exp_done_q.size() == 0)
                    check_val("done_unexpected", 32'(done), 32'd0);
                else
                    check_val("done_winner", 32'(done), 32'(exp_done_q.pop_front()));
            end
        end
        prev_load = load;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // T1: reset state
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check_val("rst_bus_out", 32'(bus_out), 32'd0);
        check_val("rst_load", 32'(load), 32'd0);
        check_val("rst_port_ready", 32'(port_ready), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_timeout_err", 32'(timeout_err), 32'd0);

        // T2: single requester, ack three cycles after port_ready
        set_data(0, 8'h0A);
        push_exp(4'b0001, 8'h0A);
        req = 4'b0001;
        @(negedge clk);
        check_val("t2_load_latency", 32'(load), 32'd1);
        check_val("t2_bus_out", 32'(bus_out), 32'h0A);
        @(negedge clk);
        check_val("t2_ready_latency", 32'(port_ready), 32'd1);
        check_val("t2_load_dropped", 32'(load), 32'd0);
        repeat (3) @(negedge clk);
        check_val("t2_ready_held", 32'(port_ready), 32'd1);
        man_ack = 1'b1;
        @(negedge clk);
        check_val("t2_done", 32'(done), 32'b0001);
        check_val("t2_ready_cleared", 32'(port_ready), 32'd0);
        check_val("t2_busy_release", 32'(busy), 32'd1);
        man_ack = 1'b0;
        req = '0;
        @(negedge clk);
        check_val("t2_busy_idle", 32'(busy), 32'd0);
        check_val("t2_bus_out_hold", 32'(bus_out), 32'h0A);

        // T3: all four requesting, immediate ack, strict round robin from pointer 0
        pulse_clr();
        for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));
        push_exp(4'b0001, 8'h10);
        push_exp(4'b0010, 8'h11);
        push_exp(4'b0100, 8'h12);
        push_exp(4'b1000, 8'h13);
        push_exp(4'b0001, 8'h10);
        auto_ack = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_for("t3_done", 2, 20);
        req = '0;
        repeat (3) @(negedge clk);

        // T4: grant req1, ack held high after done while req0 waits
        auto_ack = 1'b0;
        set_data(0, 8'h20);
        set_data(1, 8'h21);
        push_exp(4'b0010, 8'h21);
        req = 4'b0010;
        wait_for("t4_ready", 1, 10);
        req = 4'b0011;
        man_ack = 1'b1;
        wait_for("t4_done1", 2, 10);
        req = 4'b0001;
        push_exp(4'b0001, 8'h20);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("t4_no_load_while_ack", 32'(load), 32'd0);
        end
        man_ack = 1'b0;
        auto_ack = 1'b1;
        wait_for("t4_load0", 0, 5);
        check_val("t4_bus_out0", 32'(bus_out), 32'h20);
        wait_for("t4_done0", 2, 10);
        req = '0;
        repeat (3) @(negedge clk);

        // T5: reset in the middle of a handshake
        auto_ack = 1'b0;
        set_data(2, 8'h55);
        push_exp(4'b0100, 8'h55);
        req = 4'b0100;
        wait_for("t5_ready", 1, 10);
        clr = 1'b1;
        #1;
        check_val("t5_ready_async", 32'(port_ready), 32'd0);
        check_val("t5_busy_async", 32'(busy), 32'd0);
        check_val("t5_bus_out_async", 32'(bus_out), 32'd0);
        check_val("t5_done_async", 32'(done), 32'd0);
        exp_done_q.delete();
        req = '0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));
        push_exp(4'b0001, 8'h10);
        auto_ack = 1'b1;
        req = 4'b1111;
        wait_for("t5_done_after_rst", 2, 20);
        req = '0;
        repeat (3) @(negedge clk);

        // T6: device never acknowledges
        auto_ack = 1'b0;
        set_data(0, 8'h66);
        push_exp(4'b0001, 8'h66);
        req = 4'b0001;
        wait_for("t6_ready", 1, 10);
`ifdef OUTPORT_TIMEOUT_EN
        cyc = 0;
        while (!timeout_err && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("t6_timeout_latency", 32'(cyc), 32'd10);
        check_val("t6_timeout_done", 32'(done), 32'b0001);
        check_val("t6_timeout_ready", 32'(port_ready), 32'd0);
        req = '0;
        @(negedge clk);
        check_val("t6_timeout_err_pulse", 32'(timeout_err), 32'd0);
        check_val("t6_idle_busy", 32'(busy), 32'd0);
`else
        cyc = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (port_ready && !timeout_err) cyc++;
        end
        check_val("t6_ready_held_120", 32'(cyc), 32'd120);
        req = '0;
        pulse_clr();
        exp_done_q.delete();
`endif
        repeat (5) @(negedge clk);
        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check_val("exp_done_q_drained", 32'(exp_done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
